// File: rtl/uart_tx_framer.sv
// UART transmitter: frames one byte per valid/ready handshake as start, 8 data bits
// (LSB first), optional parity and 1 or 2 stop bits.
module uart_tx_framer #(
  parameter int unsigned FREQ_CLK  = 32'd100000000,
  parameter int unsigned TX_SPEED  = 32'd115200,
  parameter int unsigned PARITY    = 32'd0,
  parameter int unsigned STOP_BITS = 32'd1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       TX_Valid,
  input  logic [7:0] TX_DataIn,
  output logic       TX_Ready,
  output logic       TXD,
  output logic       TX_Busy
);

  localparam int unsigned BIT_CYCLES = FREQ_CLK / TX_SPEED;
  localparam int CW = (BIT_CYCLES > 32'd1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 32'd1);
  localparam logic STOP_LAST = (STOP_BITS == 32'd2) ? 1'b1 : 1'b0;
  localparam logic HAS_PARITY = (PARITY != 32'd0) ? 1'b1 : 1'b0;

  if (PARITY > 32'd2) begin : g_bad_parity
    $error("uart_tx_framer: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 32'd1) || (STOP_BITS > 32'd2)) begin : g_bad_stop
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (BIT_CYCLES < 32'd2) begin : g_bad_baud
    $error("uart_tx_framer: FREQ_CLK / TX_SPEED must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t        state_r;
  logic [CW-1:0] baud_r;
  logic [2:0]    idx_r;
  logic          stop_r;
  logic [7:0]    data_r;
  logic          txd_r;
  logic          ready_r;
  logic          busy_r;

  // Even parity is the XOR of the byte; odd parity is its inverse.
  function automatic logic parity_bit(input logic [7:0] d, input int unsigned mode);
    return (^d) ^ ((mode == 32'd2) ? 1'b1 : 1'b0);
  endfunction

  // Frame sequencer: every state change happens on a bit-period boundary, so TXD only moves there.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r <= IDLE;
      baud_r  <= '0;
      idx_r   <= 3'd0;
      stop_r  <= 1'b0;
      data_r  <= 8'd0;
      txd_r   <= 1'b1;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (TX_Valid && ready_r) begin
            data_r  <= TX_DataIn;
            state_r <= START;
            txd_r   <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            baud_r  <= '0;
            idx_r   <= 3'd0;
            stop_r  <= 1'b0;
          end else begin
            txd_r   <= 1'b1;
          end
        end
        START: begin
          if (baud_r == BAUD_LAST) begin
            baud_r  <= '0;
            state_r <= DATA;
            idx_r   <= 3'd0;
            txd_r   <= data_r[0];
          end else begin
            baud_r  <= baud_r + 1'b1;
          end
        end
        DATA: begin
          if (baud_r == BAUD_LAST) begin
            baud_r <= '0;
            if (idx_r == 3'd7) begin
              if (HAS_PARITY) begin
                state_r <= PAR;
                txd_r   <= parity_bit(data_r, PARITY);
              end else begin
                state_r <= STOP;
                txd_r   <= 1'b1;
                stop_r  <= 1'b0;
              end
            end else begin
              idx_r <= idx_r + 3'd1;
              txd_r <= data_r[idx_r + 3'd1];
            end
          end else begin
            baud_r <= baud_r + 1'b1;
          end
        end
        PAR: begin
          if (baud_r == BAUD_LAST) begin
            baud_r  <= '0;
            state_r <= STOP;
            txd_r   <= 1'b1;
            stop_r  <= 1'b0;
          end else begin
            baud_r  <= baud_r + 1'b1;
          end
        end
        STOP: begin
          if (baud_r == BAUD_LAST) begin
            baud_r <= '0;
            if (stop_r == STOP_LAST) begin
              state_r <= IDLE;
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
              txd_r   <= 1'b1;
            end else begin
              stop_r  <= 1'b1;
            end
          end else begin
            baud_r <= baud_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          baud_r  <= '0;
          idx_r   <= 3'd0;
          stop_r  <= 1'b0;
          txd_r   <= 1'b1;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign TXD      = txd_r;
  assign TX_Ready = ready_r;
  assign TX_Busy  = busy_r;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: five instances (8N1, 8E1, 8O1, 8E2 at 10 clocks/bit, 8N1 at defaults)
// checked every cycle against a frame-level model plus directed literal expectations.
module tb_uart_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rst_n;
  logic [4:0] valid;
  logic [4:0] ready;
  logic [4:0] txd;
  logic [4:0] busy;
  logic [7:0] data [5];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int acc_t [5];
  logic [11:0] frm [5];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    uart_tx_framer #(
      .FREQ_CLK  ((g == 4) ? 32'd100000000 : 32'd10),
      .TX_SPEED  ((g == 4) ? 32'd115200 : 32'd1),
      .PARITY    ((g == 1 || g == 3) ? 32'd1 : ((g == 2) ? 32'd2 : 32'd0)),
      .STOP_BITS ((g == 3) ? 32'd2 : 32'd1)
    ) u_dut (
      .Clk       (clk),
      .Rst_n     (rst_n[g]),
      .TX_Valid  (valid[g]),
      .TX_DataIn (data[g]),
      .TX_Ready  (ready[g]),
      .TXD       (txd[g]),
      .TX_Busy   (busy[g])
    );
  end

  function automatic int par_of(int i);
    return (i == 1 || i == 3) ? 1 : ((i == 2) ? 2 : 0);
  endfunction

  function automatic int stops_of(int i);
    return (i == 3) ? 2 : 1;
  endfunction

  function automatic int bc_of(int i);
    return (i == 4) ? (100000000 / 115200) : (10 / 1);
  endfunction

  function automatic int nbits_of(int i);
    return 1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stops_of(i);
  endfunction

  // Whole frame as line levels, bit 0 first; unused upper positions stay idle-high.
  function automatic logic [11:0] build(int i, logic [7:0] d);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par_of(i) != 0) f[9] = (^d) ^ (par_of(i) == 2);
    return f;
  endfunction

  task automatic chk(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: track accept edge per line, expected outputs follow from elapsed clocks.
  always @(posedge clk) begin : model
    int k;
    logic [2:0] exp_o;
    cyc++;
    for (int i = 0; i < 5; i++) begin
      if (rst_n[i] == 1'b0) acc_t[i] = -1;
      else if (acc_t[i] >= 0 && (cyc - acc_t[i]) == nbits_of(i) * bc_of(i)) acc_t[i] = -1;
      else if (acc_t[i] < 0 && valid[i] == 1'b1) begin
        acc_t[i] = cyc;
        frm[i]   = build(i, data[i]);
      end
    end
    #1;
    for (int i = 0; i < 5; i++) begin
      if (acc_t[i] < 0) exp_o = 3'b110;
      else begin
        k     = cyc - acc_t[i];
        exp_o = {frm[i][k / bc_of(i)], 1'b0, 1'b1};
      end
      chk($sformatf("model_line%0d", i), {txd[i], ready[i], busy[i]}, exp_o);
    end
  end

  // Called just after a posedge with the line idle; returns just after the accept edge.
  task automatic start(int i, logic [7:0] d, bit hold);
    valid[i] = 1'b1;
    data[i]  = d;
    tick();
    chk($sformatf("accept_line%0d", i), ready[i], 0);
    if (!hold) valid[i] = 1'b0;
  endtask

  // Called just after the accept edge; samples each bit mid-period, then waits (bounded) for ready.
  task automatic capture(int i, output logic [11:0] bits, output int rlen);
    int b, n, k;
    b    = bc_of(i);
    n    = nbits_of(i);
    bits = '1;
    repeat (b / 2) tick();
    bits[0] = txd[i];
    for (int j = 1; j < n; j++) begin
      repeat (b) tick();
      bits[j] = txd[i];
    end
    k = (n - 1) * b + b / 2;
    while (ready[i] == 1'b0 && k < n * b + 5) begin
      tick();
      k++;
    end
    rlen = k;
  endtask

  initial begin : stim
    logic [11:0] bits;
    int len, lows;
    for (int i = 0; i < 5; i++) begin
      acc_t[i] = -1;
      data[i]  = 8'h00;
    end
    rst_n = '0;
    valid = '0;

    // Reset and idle
    repeat (5) begin
      tick();
      for (int i = 0; i < 5; i++) chk($sformatf("reset_line%0d", i), {txd[i], ready[i], busy[i]}, 3'b110);
    end
    rst_n = '1;
    lows  = 0;
    repeat (200) begin
      tick();
      for (int i = 0; i < 5; i++) lows += ((txd[i] == 1'b0) ? 1 : 0) + ((ready[i] == 1'b0) ? 1 : 0);
    end
    chk("idle_activity", lows, 0);

    // 8N1 0x77
    start(0, 8'h77, 1'b0);
    capture(0, bits, len);
    chk("8n1_bits", bits[9:0], 10'b1011101110);
    chk("8n1_ready_low", len, 100);

    // Parity
    start(1, 8'hAA, 1'b0);
    capture(1, bits, len);
    chk("even_aa_parity", bits[9], 0);
    chk("even_aa_data", bits[8:1], 8'hAA);
    chk("even_len", len, 110);
    start(2, 8'hAA, 1'b0);
    capture(2, bits, len);
    chk("odd_aa_parity", bits[9], 1);
    chk("odd_len", len, 110);
    start(1, 8'h03, 1'b0);
    capture(1, bits, len);
    chk("even_03_parity", bits[9], 0);
    start(3, 8'hAA, 1'b0);
    capture(3, bits, len);
    chk("e2_parity", bits[9], 0);
    chk("e2_stops", bits[11:10], 2'b11);
    chk("e2_len", len, 120);

    // Back-to-back with data switched right after the first accept
    tick();
    start(0, 8'hAA, 1'b1);
    data[0] = 8'hBB;
    capture(0, bits, len);
    chk("b2b_first_data", bits[8:1], 8'hAA);
    chk("b2b_first_len", len, 100);
    chk("b2b_gap_idle", txd[0], 1);
    tick();
    chk("b2b_second_start", {txd[0], ready[0]}, 2'b00);
    valid[0] = 1'b0;
    capture(0, bits, len);
    chk("b2b_second_bits", bits[9:0], {1'b1, 8'hBB, 1'b0});
    chk("b2b_second_len", len, 100);

    // Busy ignore: offer 0x55 at clock 30 of a frame in flight
    tick();
    start(0, 8'h11, 1'b0);
    fork
      capture(0, bits, len);
      begin
        repeat (29) tick();
        valid[0] = 1'b1;
        data[0]  = 8'h55;
        tick();
        valid[0] = 1'b0;
        data[0]  = 8'h00;
      end
    join
    chk("busy_keep_data", bits[9:0], {1'b1, 8'h11, 1'b0});
    lows = 0;
    repeat (20) begin
      tick();
      lows += (ready[0] == 1'b0) ? 1 : 0;
    end
    chk("busy_no_second", lows, 0);

    // Mid-frame reset during data bit 3, then a clean 0xCC frame
    start(0, 8'h5A, 1'b0);
    repeat (44) tick();
    rst_n[0] = 1'b0;
    tick();
    chk("midreset_idle", {txd[0], ready[0], busy[0]}, 3'b110);
    rst_n[0] = 1'b1;
    tick();
    start(0, 8'hCC, 1'b0);
    capture(0, bits, len);
    chk("after_reset_bits", bits[9:0], {1'b1, 8'hCC, 1'b0});
    chk("after_reset_len", len, 100);

    // Default timing, 868 clocks per bit
    start(4, 8'h55, 1'b0);
    capture(4, bits, len);
    chk("default_bits", bits[9:0], 10'b1010101010);
    chk("default_len", len, 8680);

    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Serial 8-bit UART transmitter, LSB first, with configurable parity and stop bits.
- Accepts one byte at a time over a valid/ready handshake from the DMA transmit path.
- Drives TXD as the line-level peer of the serial receiver path.
- Sits between the DMA TX_Data/TX_Valid/TX_Ready interface and the board TXD pin.

Parameters:
- FREQ_CLK, 100000000: system clock frequency in Hz (32-bit).
- TX_SPEED, 115200: baud rate in bit/s (32-bit).
- PARITY, 0: parity mode. 0 = none, 1 = even, 2 = odd. Other values are an elaboration error.
- STOP_BITS, 1: number of stop bits, 1 or 2. Other values are an elaboration error.
- Derived BIT_CYCLES = FREQ_CLK / TX_SPEED, integer division (868 at defaults). Elaboration error if BIT_CYCLES < 2.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- TX_Valid  in  1  byte on TX_DataIn is offered.
- TX_DataIn  in  8  byte to send; bit 0 goes first.
- TX_Ready  out  1  framer idle, can accept a byte.
- TXD  out  1  serial line; idle high.
- TX_Busy  out  1  frame in progress; equals the inverse of TX_Ready.

Behaviour:
- Reset: at any posedge with Rst_n=0, state=IDLE, TXD=1, TX_Ready=1, TX_Busy=0, counters=0, shift register=0.
- Reset mid-frame aborts immediately: TXD=1 from the next edge; the partial frame is not resumed.
- All outputs are registered.
- Accept: at a posedge with TX_Valid=1 and TX_Ready=1, the following happen at that same edge:
  - TX_DataIn is latched.
  - State goes to START, TXD<=0, TX_Ready<=0.
- TX_Valid while TX_Ready=0 is ignored; no queuing.
- TX_DataIn changes after the accept edge do not affect the frame in flight.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Each bit period is exactly BIT_CYCLES clocks, timed by a baud counter 0..BIT_CYCLES-1. The counter clears on every state or bit change.
  - START: TXD=0 for one bit period.
  - DATA: 3-bit index 0..7. TXD = latched[index]. Index increments every bit period. Leave after index 7 completes.
  - PARITY: entered only if PARITY≠0. TXD = XOR of the 8 latched bits (even) or its inverse (odd). One bit period.
  - STOP: TXD=1 for STOP_BITS bit periods.
  - At the end of STOP, state returns to IDLE and TX_Ready<=1 at that edge.
- Frame length from the accept edge to the TX_Ready rising edge: N×BIT_CYCLES clocks, where N = 1 + 8 + (PARITY≠0) + STOP_BITS.
  - 8N1 at defaults: N = 10, i.e. 8680 clocks.
- Back-to-back: with TX_Valid held high, the next accept happens on the edge after TX_Ready rises.
  - This gives an inter-frame gap of exactly 1 clock of idle-high on TXD.
- TXD never glitches: it changes only at bit-period boundaries or on reset.
- Parity is computed from the latched byte, not from the live input.

Test Plan:
- Timing setup: FREQ_CLK=10, TX_SPEED=1 (BIT_CYCLES=10), unless stated otherwise.
- Reset/idle: hold Rst_n=0 for 5 clocks, then release. Required: TXD=1, TX_Ready=1, TX_Busy=0 throughout; no TXD activity with TX_Valid=0 for 200 clocks.
- 8N1 byte 0x77: pulse TX_Valid for one cycle.
  - TXD sampled mid-bit = 0,1,1,1,0,1,1,1,0,1.
  - TX_Ready low exactly 100 clocks, high again at accept+100.
- Parity, sending 0xAA (four ones):
  - PARITY=1: bit 10 = 0.
  - PARITY=2: bit 10 = 1.
  - PARITY=1 with 0x03 sent: bit 10 = 0.
  - Parity-case frame length = 110 clocks.
  - STOP_BITS=2 with PARITY=1: 120 clocks.
- Back-to-back 0xAA then 0xBB, TX_Valid held high, DataIn switched to 0xBB the cycle after the first accept:
  - Second start bit begins exactly 1 clock after TX_Ready rises.
  - Second frame decodes as 0xBB.
  - The first frame is unaffected by the DataIn change.
- Busy ignore: TX_Valid=1 with 0x55 at clock 30 of a frame in flight. Required: no second frame; the current byte completes unchanged.
- Mid-frame reset: assert Rst_n=0 for 1 clock during DATA bit 3. Required: TXD=1 and TX_Ready=1 at the next edge; a new 0xCC frame afterwards transmits correctly.
- Default timing: FREQ_CLK=100000000, TX_SPEED=115200, send 0x55. Required: each bit is 868 clocks and TX_Ready returns at accept+8680.
